// File: rtl/clk_phase_checker_if.sv
// Bundle between the phase checker and whoever drives/observes it.
// master: drives the sampled phases and the error-clear, observes status.
// slave : the checker side (consumes ph_in/clr_err, drives status outputs).
interface clk_phase_checker_if #(
  parameter int ERR_W = 16
);
  logic [3:0]       ph_in;      // {clk_270, clk_180, clk_90, clk_0}
  logic             clr_err;    // synchronous clear of err_count
  logic             locked;     // rotating pattern tracked
  logic [1:0]       phase_idx;  // current step while locked, else 0
  logic             err_pulse;  // one cycle per violation seen while locked
  logic [ERR_W-1:0] err_count;  // saturating violation count

  modport master (
    output ph_in, clr_err,
    input  locked, phase_idx, err_pulse, err_count
  );

  modport slave (
    input  ph_in, clr_err,
    output locked, phase_idx, err_pulse, err_count
  );
endinterface

// File: rtl/clk_phase_checker.sv
// Checks the four-phase divide-by-4 clock set on the master clock and declares lock.
// Ports: clk, rst (async active-low), bus (slave modport: ph_in, clr_err in;
//        locked, phase_idx, err_pulse, err_count out). Outputs lag ph_in by SYNC_STAGES+1 edges.
module clk_phase_checker #(
  parameter int LOCK_CNT    = 8,
  parameter int SYNC_STAGES = 1,
  parameter int ERR_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  clk_phase_checker_if.slave    bus
);

  localparam int CNT_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CNT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic {ACQ, LOCKED} state_t;

  // Legal one-hot-pair codes and the step each represents.
  function automatic logic is_legal(input logic [3:0] c);
    return (c == 4'h9) || (c == 4'h3) || (c == 4'h6) || (c == 4'hC);
  endfunction

  function automatic logic [1:0] step_of(input logic [3:0] c);
    logic [1:0] r;
    r = 2'd0;
    case (c)
      4'h3:    r = 2'd1;
      4'h6:    r = 2'd2;
      4'hC:    r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Input sampling chain; s is the newest sample, p the one before it.
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] s;
  logic [3:0] p;
  logic       valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b0000;
      p <= 4'b0000;
    end else begin
      sync_q[0] <= bus.ph_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      p <= s;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // The pattern advances by one 90-degree step per cycle: the new code is the
  // previous one rotated left by one. Holds and skips both fail this test.
  assign valid = is_legal(s) && (s == {p[2:0], p[3]});

  state_t           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             locked_q, locked_d;
  logic [1:0]       idx_q,    idx_d;
  logic             pulse_q,  pulse_d;
  logic [ERR_W-1:0] errc_q,   errc_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ACQ;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      idx_q    <= 2'd0;
      pulse_q  <= 1'b0;
      errc_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      idx_q    <= idx_d;
      pulse_q  <= pulse_d;
      errc_q   <= errc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    locked_d = locked_q;
    idx_d    = idx_q;
    pulse_d  = 1'b0;
    errc_d   = errc_q;

    case (state_q)
      ACQ: begin
        // Mismatches while acquiring just restart the run; they are not errors.
        if (valid) begin
          if (cnt_q == CNT_LAST) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
            idx_d    = step_of(s);
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      LOCKED: begin
        if (valid) begin
          idx_d = step_of(s);
        end else begin
          state_d  = ACQ;
          locked_d = 1'b0;
          idx_d    = 2'd0;
          pulse_d  = 1'b1;
          cnt_d    = '0;
          if (errc_q != ERR_MAX) errc_d = errc_q + 1'b1;
        end
      end
      default: begin
        state_d  = ACQ;
        locked_d = 1'b0;
        idx_d    = 2'd0;
        cnt_d    = '0;
      end
    endcase

    // Clear has priority over a coincident increment; the pulse is unaffected.
    if (bus.clr_err) errc_d = '0;
  end

  assign bus.locked    = locked_q;
  assign bus.phase_idx = idx_q;
  assign bus.err_pulse = pulse_q;
  assign bus.err_count = errc_q;

endmodule

// File: tb/tb_clk_phase_checker.sv
module tb_clk_phase_checker;

  logic clk;
  logic rst;

  // A 2-bit error counter lets saturation be reached with a handful of violations.
  clk_phase_checker_if #(.ERR_W(2)) bus ();

  clk_phase_checker #(
    .LOCK_CNT   (8),
    .SYNC_STAGES(1),
    .ERR_W      (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         at;
    logic       lk;
    logic [1:0] idx;
    logic       ep;
    logic [1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] fwd [4];
  logic [3:0] rev [4];
  int         pos = 0;

  // Scoreboard monitor: compares each expectation at the cycle it targets.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      if (q[0].at < cyc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_expectation at=%0d now=%0d", e.at, cyc);
      end else if (q[0].at == cyc) begin
        e = q.pop_front();
        checks++;
        if (bus.locked !== e.lk || bus.phase_idx !== e.idx ||
            bus.err_pulse !== e.ep || bus.err_count !== e.cnt) begin
          errors++;
          $display("FAIL outputs cyc=%0d got lk=%b idx=%0d ep=%b cnt=%0d want lk=%b idx=%0d ep=%b cnt=%0d",
                   cyc, bus.locked, bus.phase_idx, bus.err_pulse, bus.err_count,
                   e.lk, e.idx, e.ep, e.cnt);
        end
      end
    end
  end

  // Drive one code; it is sampled on the next edge and seen at the outputs one edge later.
  task automatic step(input logic [3:0] code);
    bus.ph_in = code;
    @(posedge clk);
    #1;
  endtask

  task automatic step_exp(input logic [3:0] code, input logic lk, input logic [1:0] idx,
                          input logic ep, input logic [1:0] cnt);
    exp_t x;
    x.at = cyc + 2; x.lk = lk; x.idx = idx; x.ep = ep; x.cnt = cnt;
    q.push_back(x);
    step(code);
  endtask

  // Forward stream; locked is expected from the lock_after-th code onward.
  task automatic stream(input int n, input int lock_after, input logic [1:0] cnt);
    for (int t = 0; t < n; t++) begin
      logic lk;
      lk = (t >= lock_after);
      step_exp(fwd[pos], lk, lk ? 2'(pos) : 2'd0, 1'b0, cnt);
      pos = (pos + 1) % 4;
    end
  endtask

  // Keep the clean stream running until every expectation has been compared.
  task automatic drain();
    for (int k = 0; k < 10 && q.size() != 0; k++) begin
      step(fwd[pos]);
      pos = (pos + 1) % 4;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d want 0", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.ph_in = 4'h0;
    bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    pos = 0;
  endtask

  task automatic direct_check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    fwd[0] = 4'h9; fwd[1] = 4'h3; fwd[2] = 4'h6; fwd[3] = 4'hC;
    rev[0] = 4'hC; rev[1] = 4'h6; rev[2] = 4'h3; rev[3] = 4'h9;
    rst = 1'b0;
    bus.ph_in = 4'h0;
    bus.clr_err = 1'b0;
    #1;
    direct_check("reset_locked", int'(bus.locked), 0);
    direct_check("reset_idx", int'(bus.phase_idx), 0);
    direct_check("reset_pulse", int'(bus.err_pulse), 0);
    direct_check("reset_count", int'(bus.err_count), 0);

    // 1: clean stream locks on edge 10, then phase_idx cycles 0..3.
    do_reset();
    stream(16, 8, 2'd0);

    // 2: hold C -> one error, then relock after 8 valid transitions.
    step_exp(4'hC, 1'b0, 2'd0, 1'b1, 2'd1);
    pos = 0;
    stream(12, 7, 2'd1);
    drain();

    // 3: single illegal code while locked; then reverse order never locks.
    do_reset();
    stream(10, 8, 2'd0);
    step_exp(4'hF, 1'b0, 2'd0, 1'b1, 2'd1);
    stream(4, 99, 2'd1);
    for (int t = 0; t < 16; t++) step_exp(rev[t % 4], 1'b0, 2'd0, 1'b0, 2'd1);
    drain();

    // 4: garbage during acquisition is silent.
    do_reset();
    step_exp(4'hF, 1'b0, 2'd0, 1'b0, 2'd0);
    step_exp(4'h0, 1'b0, 2'd0, 1'b0, 2'd0);
    step_exp(4'h5, 1'b0, 2'd0, 1'b0, 2'd0);
    step_exp(4'h9, 1'b0, 2'd0, 1'b0, 2'd0);
    step_exp(4'h9, 1'b0, 2'd0, 1'b0, 2'd0);
    step_exp(4'hA, 1'b0, 2'd0, 1'b0, 2'd0);
    step_exp(4'h3, 1'b0, 2'd0, 1'b0, 2'd0);
    step_exp(4'h3, 1'b0, 2'd0, 1'b0, 2'd0);
    drain();

    // 5: five violations saturate the 2-bit count at 3; clear beats a coincident violation.
    do_reset();
    stream(10, 8, 2'd0);
    for (int k = 1; k <= 5; k++) begin
      logic [1:0] c;
      c = (k > 3) ? 2'd3 : 2'(k);
      step_exp(4'hF, 1'b0, 2'd0, 1'b1, c);
      stream(10, 8, c);
    end
    step_exp(4'hF, 1'b0, 2'd0, 1'b1, 2'd0);
    bus.clr_err = 1'b1;
    step_exp(fwd[pos], 1'b0, 2'd0, 1'b0, 2'd0);
    bus.clr_err = 1'b0;
    pos = (pos + 1) % 4;
    stream(4, 99, 2'd0);
    drain();

    // 6: asynchronous reset while locked with a nonzero count clears everything at once.
    do_reset();
    stream(10, 8, 2'd0);
    step_exp(4'hF, 1'b0, 2'd0, 1'b1, 2'd1);
    stream(10, 8, 2'd1);
    drain();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    direct_check("async_rst_locked", int'(bus.locked), 0);
    direct_check("async_rst_idx", int'(bus.phase_idx), 0);
    direct_check("async_rst_count", int'(bus.err_count), 0);
    direct_check("async_rst_pulse", int'(bus.err_pulse), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.ph_in = 4'h0;
    pos = 0;
    stream(12, 8, 2'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
